// File: rtl/gin_pkg.sv
// Shared GIN definitions: default field widths, endpoint config record and tag matching.
package gin_pkg;

    localparam int unsigned GIN_ID_BITS      = 5;
    localparam int unsigned GIN_DATA_BITS    = 32;
    localparam int unsigned GIN_TAG_MAX_BITS = 32;

    typedef logic [GIN_TAG_MAX_BITS-1:0] gin_tag_t;

    // Fields are held at the widest supported tag size; narrower endpoints zero-extend.
    typedef struct packed {
        gin_tag_t id;
        gin_tag_t mask;
        logic     en;
    } gin_cfg_t;

    // Mask bit 1 = compared, 0 = don't care.
    function automatic logic gin_tag_match(input gin_tag_t tag, input gin_tag_t id,
                                           input gin_tag_t mask, input logic en);
        return en && (((tag ^ id) & mask) == '0);
    endfunction

endpackage

// File: rtl/gin_sync_fifo.sv
// Synchronous FIFO with registered storage; head entry is presented with no added latency.
module gin_sync_fifo #(
    parameter int unsigned DATA_SIZE = 32,
    parameter int unsigned DEPTH     = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push,
    input  logic                 pop,
    input  logic                 flush,
    input  logic [DATA_SIZE-1:0] wdata,
    output logic                 full,
    output logic                 empty,
    output logic [DATA_SIZE-1:0] rdata
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [DATA_SIZE-1:0] mem [DEPTH];
    // Extra MSB distinguishes full from empty when the index bits coincide.
    logic [AW:0]          wptr;
    logic [AW:0]          rptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) begin
                mem[wptr[AW-1:0]] <= wdata;
                wptr              <= wptr + (AW+1)'(1);
            end
            if (pop) begin
                rptr <= rptr + (AW+1)'(1);
            end
        end
    end

    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign rdata = mem[rptr[AW-1:0]];

endmodule

// File: rtl/gin_mc_buffered_controller.sv
// GIN multicast endpoint: masked tag match, buffered delivery to the PE and a delivered-packet counter.
module gin_mc_buffered_controller
    import gin_pkg::*;
#(
    parameter int unsigned ID_SIZE   = GIN_ID_BITS,
    parameter int unsigned DATA_SIZE = GIN_DATA_BITS,
    parameter int unsigned DEPTH     = 2,
    parameter int unsigned CNT_BITS  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 set_id,
    input  logic [ID_SIZE-1:0]   id_in,
    input  logic [ID_SIZE-1:0]   mask_in,
    input  logic                 en_in,
    output logic [ID_SIZE-1:0]   id,
    input  logic                 flush,
    input  logic [ID_SIZE-1:0]   tag,
    input  logic [DATA_SIZE-1:0] data_in,
    input  logic                 valid_in,
    output logic                 ready_out,
    output logic [DATA_SIZE-1:0] data_out,
    output logic                 valid_out,
    input  logic                 ready_in,
    output logic                 match,
    input  logic                 count_clr,
    output logic [CNT_BITS-1:0]  pkt_count
);

    gin_cfg_t cfg;
    logic     full;
    logic     empty;
    logic     push;
    logic     pop;

    // Reset config answers exactly tag 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            cfg.id   <= '0;
            cfg.mask <= GIN_TAG_MAX_BITS'({ID_SIZE{1'b1}});
            cfg.en   <= 1'b1;
        end else if (set_id) begin
            cfg.id   <= GIN_TAG_MAX_BITS'(id_in);
            cfg.mask <= GIN_TAG_MAX_BITS'(mask_in);
            cfg.en   <= en_in;
        end
    end

    assign id    = cfg.id[ID_SIZE-1:0];
    assign match = gin_tag_match(GIN_TAG_MAX_BITS'(tag), cfg.id, cfg.mask, cfg.en);

    // Full blocks the push outright, so ready_out never depends on ready_in.
    assign ready_out = match && !full;
    assign push      = valid_in && ready_out;
    assign valid_out = !empty;
    assign pop       = valid_out && ready_in;

    gin_sync_fifo #(
        .DATA_SIZE (DATA_SIZE),
        .DEPTH     (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .wdata (data_in),
        .full  (full),
        .empty (empty),
        .rdata (data_out)
    );

    // A pop cancelled by a flush is not a delivery.
    always_ff @(posedge clk) begin
        if (rst || count_clr) begin
            pkt_count <= '0;
        end else if (pop && !flush) begin
            pkt_count <= pkt_count + CNT_BITS'(1);
        end
    end

endmodule

// File: tb/tb_gin_mc_buffered_controller.sv
// Scoreboard bench for gin_mc_buffered_controller: directed scenarios followed by randomized traffic.
module tb_gin_mc_buffered_controller;

    localparam int unsigned IDW   = 5;
    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 2;
    localparam int unsigned CW    = 16;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           set_id = 1'b0;
    logic [IDW-1:0] id_in = '0;
    logic [IDW-1:0] mask_in = '0;
    logic           en_in = 1'b0;
    logic [IDW-1:0] id;
    logic           flush = 1'b0;
    logic [IDW-1:0] tag = '0;
    logic [DW-1:0]  data_in = '0;
    logic           valid_in = 1'b0;
    logic           ready_out;
    logic [DW-1:0]  data_out;
    logic           valid_out;
    logic           ready_in = 1'b0;
    logic           match;
    logic           count_clr = 1'b0;
    logic [CW-1:0]  pkt_count;

    gin_mc_buffered_controller #(
        .ID_SIZE   (IDW),
        .DATA_SIZE (DW),
        .DEPTH     (DEPTH),
        .CNT_BITS  (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .set_id    (set_id),
        .id_in     (id_in),
        .mask_in   (mask_in),
        .en_in     (en_in),
        .id        (id),
        .flush     (flush),
        .tag       (tag),
        .data_in   (data_in),
        .valid_in  (valid_in),
        .ready_out (ready_out),
        .data_out  (data_out),
        .valid_out (valid_out),
        .ready_in  (ready_in),
        .match     (match),
        .count_clr (count_clr),
        .pkt_count (pkt_count)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: endpoint config, buffer occupancy, delivered count, expected payload order.
    logic [IDW-1:0] m_id;
    logic [IDW-1:0] m_mask;
    logic           m_en;
    int             m_occ;
    logic [CW-1:0]  m_count;
    bit             model_valid = 1'b0;
    logic [DW-1:0]  exp_q[$];

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Delivered payloads are compared in order against what the model accepted.
    always @(negedge clk) begin
        if (model_valid && !rst && !flush && valid_out === 1'b1 && ready_in === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_pop: got data 0x%0h, expected no delivery at %0t", data_out, $time);
            end else begin
                check("data_out", data_out, exp_q.pop_front());
            end
        end
    end

    // One clock of stimulus; outputs checked at negedge against the model, model then advanced.
    task automatic step(input logic r, input logic s, input logic [IDW-1:0] iid,
                        input logic [IDW-1:0] imask, input logic ien, input logic fl,
                        input logic [IDW-1:0] tg, input logic [DW-1:0] d,
                        input logic vi, input logic ri, input logic cc);
        logic exp_match;
        logic exp_ready;
        logic do_push;
        logic do_pop;
        rst = r; set_id = s; id_in = iid; mask_in = imask; en_in = ien; flush = fl;
        tag = tg; data_in = d; valid_in = vi; ready_in = ri; count_clr = cc;
        @(negedge clk);
        exp_match = m_en && (((tg ^ m_id) & m_mask) == '0);
        exp_ready = exp_match && (m_occ < int'(DEPTH));
        if (model_valid) begin
            check("match", DW'(match), DW'(exp_match));
            check("ready_out", DW'(ready_out), DW'(exp_ready));
            check("valid_out", DW'(valid_out), DW'(m_occ > 0));
            check("id", DW'(id), DW'(m_id));
            check("pkt_count", DW'(pkt_count), DW'(m_count));
        end
        do_push = vi && exp_ready;
        do_pop  = (m_occ > 0) && ri;
        if (r) begin
            m_id = '0; m_mask = '1; m_en = 1'b1; m_occ = 0; m_count = '0;
            exp_q.delete();
            model_valid = 1'b1;
        end else begin
            if (fl) begin
                m_occ = 0;
                exp_q.delete();
            end else begin
                if (do_push) exp_q.push_back(d);
                m_occ = m_occ + int'(do_push) - int'(do_pop);
            end
            if (cc) m_count = '0;
            else if (do_pop && !fl) m_count = m_count + CW'(1);
            if (s) begin
                m_id = iid; m_mask = imask; m_en = ien;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic bus(input logic [IDW-1:0] tg, input logic [DW-1:0] d, input logic vi, input logic ri);
        step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, tg, d, vi, ri, 1'b0);
    endtask

    initial begin
        logic [IDW-1:0] rtag;
        logic [IDW-1:0] rid;
        logic [IDW-1:0] rmask;
        logic           rfl;
        logic           rr;
        logic           rs;
        logic [DW-1:0]  start_cnt;

        #1;
        step(1'b1, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        check("reset_data_out", data_out, '0);

        // Reset endpoint answers tag 0; payload visible next cycle, counted the cycle after.
        bus(5'h00, 32'hA5, 1'b1, 1'b1);
        bus(5'h00, 32'h0, 1'b0, 1'b1);
        bus(5'h00, 32'h0, 1'b0, 1'b1);
        check("first_count", DW'(pkt_count), 32'd1);

        // Range match 0x0C..0x0F, then a miss at 0x10.
        step(1'b0, 1'b1, 5'h0C, 5'h1C, 1'b1, 1'b0, 5'h1F, '0, 1'b0, 1'b0, 1'b0);
        for (int t = 'h0C; t <= 'h10; t++) bus(IDW'(t), '0, 1'b0, 1'b0);
        check("miss_ready_out", DW'(ready_out), 32'd0);

        // Fill to DEPTH with the PE stalled, then drain in order.
        bus(5'h0D, 32'h11, 1'b1, 1'b0);
        bus(5'h0E, 32'h22, 1'b1, 1'b0);
        bus(5'h0F, 32'h33, 1'b1, 1'b0);
        bus(5'h0F, 32'h33, 1'b0, 1'b1);
        bus(5'h0F, 32'h33, 1'b0, 1'b1);
        bus(5'h0F, 32'h00, 1'b0, 1'b0);

        // Streaming at occupancy 1.
        bus(5'h0C, 32'h100, 1'b1, 1'b0);
        start_cnt = DW'(pkt_count);
        for (int i = 1; i <= 10; i++) bus(5'h0C, DW'(32'h100 + i), 1'b1, 1'b1);
        bus(5'h0C, 32'h0, 1'b0, 1'b0);
        check("stream_count", DW'(pkt_count) - start_cnt, 32'd10);
        check("stream_occupancy", DW'(valid_out), 32'd1);

        // Flush with a full FIFO and a concurrent matched push.
        bus(5'h0C, 32'h200, 1'b1, 1'b0);
        step(1'b0, 1'b0, '0, '0, 1'b0, 1'b1, 5'h0C, 32'h201, 1'b1, 1'b0, 1'b0);
        bus(5'h0C, 32'h0, 1'b0, 1'b0);
        check("flush_valid_out", DW'(valid_out), 32'd0);

        // Disabled endpoint still drains; reset lands mid-drain.
        bus(5'h0C, 32'h300, 1'b1, 1'b0);
        bus(5'h0C, 32'h301, 1'b1, 1'b0);
        step(1'b0, 1'b1, 5'h0C, 5'h1F, 1'b0, 1'b0, 5'h0C, '0, 1'b0, 1'b0, 1'b0);
        for (int t = 0; t < 4; t++) bus(IDW'(t * 9), '0, 1'b0, 1'b0);
        bus(5'h0C, 32'h0, 1'b0, 1'b1);
        step(1'b1, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        bus(5'h00, 32'h0, 1'b0, 1'b0);
        check("post_reset_data_out", data_out, '0);

        // Randomized traffic with occasional reconfig, flush, counter clear and reset.
        for (int i = 0; i < 600; i++) begin
            rmask = IDW'($urandom);
            rtag  = ($urandom_range(0, 1) == 1) ? (m_id ^ (IDW'($urandom) & ~m_mask)) : IDW'($urandom);
            rfl   = ($urandom_range(0, 99) < 3);
            rr    = ($urandom_range(0, 199) < 1);
            rs    = ($urandom_range(0, 99) < 5);
            rid   = IDW'($urandom);
            step(rr, rs, rid, rmask, ($urandom_range(0, 7) != 0), rfl, rtag, DW'($urandom),
                 ($urandom_range(0, 3) != 0), (rfl || rr) ? 1'b0 : ($urandom_range(0, 2) != 0),
                 ($urandom_range(0, 99) < 2));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/gin_mc_buffered_controller.md
Name: gin_mc_buffered_controller

Overview:
Next-generation GIN multicast controller. Each PE-side endpoint of the GIN X/Y bus gets one instance.
- Matches the broadcast tag against a programmable ID under a programmable don't-care mask, so one packet can reach a range of PEs.
- Buffers accepted packets in a small FIFO, which decouples the bus from PE back-pressure.
- Counts delivered packets for debug and performance.
- Sits between the GIN bus (upstream) and the PE scratchpad input port (downstream).

Parameters:
ID_SIZE, 5, width of the id, mask and tag fields
DATA_SIZE, 32, packet payload width
DEPTH, 2, FIFO entries; power of two, at least 2
CNT_BITS, 16, width of the delivered-packet counter

Ports:
clk  input  1  clock
rst  input  1  synchronous, active-high reset
set_id  input  1  load id_in, mask_in and en_in into the config registers
id_in  input  ID_SIZE  ID to program
mask_in  input  ID_SIZE  compare mask; 1 = bit compared, 0 = don't care
en_in  input  1  endpoint enable to program
id  output  ID_SIZE  current programmed ID
flush  input  1  synchronous FIFO clear
tag  input  ID_SIZE  destination tag of the current bus packet
data_in  input  DATA_SIZE  bus payload
valid_in  input  1  bus packet valid
ready_out  output  1  endpoint can accept; meaningful only when matched
data_out  output  DATA_SIZE  FIFO head payload
valid_out  output  1  FIFO non-empty
ready_in  input  1  PE ready
match  output  1  current tag hits this endpoint
count_clr  input  1  synchronous clear of pkt_count
pkt_count  output  CNT_BITS  packets popped to the PE, wrap-around

Behaviour:
Reset values:
- id = 0, mask register = all ones, enable = 1 (reset endpoint answers exactly tag 0).
- FIFO empty; valid_out = 0; data_out = 0; pkt_count = 0.

Config:
- On set_id, all three config registers update on the clock edge.
- A new config affects matching from the next cycle only.
- FIFO contents are never altered by a config change.

Matching:
- match = enable && (((tag ^ id) & mask) == 0). Combinational.
- match is independent of valid_in.

Upstream handshake:
- ready_out = match && !full. Non-matching endpoints drive 0, and the bus reduction ignores them.
- ready_out has no combinational path from ready_in. When full, a pop and a push cannot happen in the same cycle.
- push = valid_in && ready_out.

Downstream handshake:
- valid_out = !empty.
- data_out = head entry, registered storage, zero added latency.
- pop = valid_out && ready_in.
- Push-to-visible latency is 1 cycle: data pushed in cycle N appears on data_out with valid_out = 1 in cycle N+1 if the FIFO was empty.

FIFO behaviour:
- Push and pop in the same cycle (not full, not empty): occupancy unchanged, order preserved.
- Read and write pointers wrap modulo DEPTH.
- Occupancy is tracked with DEPTH+1 states (pointer extra bit or counter).
- Pop when empty and push when full are impossible by construction.

Flush and reset:
- flush clears the pointers on the next edge and takes priority over a push/pop in the same cycle; the pushed data is discarded.
- Config registers and pkt_count are kept through a flush.
- rst mid-transfer discards all buffered data and restores the reset values above.

Counter:
- pkt_count increments by 1 on each pop and wraps to 0 after its maximum value.
- count_clr takes priority over an increment in the same cycle.

Decomposition:
- Shared package gin_pkg holds:
  - default constants GIN_ID_BITS = 5 and GIN_DATA_BITS = 32;
  - typedef gin_cfg_t {id, mask, en};
  - a matching function gin_tag_match(tag, id, mask, en), reused by the multicast and future unicast controllers.
- One sub-module: gin_sync_fifo (parameters DATA_SIZE, DEPTH; ports push/pop/flush, full/empty, head data).
- The top module holds the config registers, match logic, handshake glue and counter.

Test Plan:
1. Reset, then tag = 0, valid_in = 1, data_in = 0xA5, ready_in = 1 -> match = 1, ready_out = 1; next cycle valid_out = 1, data_out = 0xA5, pkt_count becomes 1 one cycle later.
2. set_id with id = 0x0C, mask = 0x1C; drive tags 0x0C..0x0F, then 0x10 -> match = 1 for 0x0C..0x0F, match = 0 and ready_out = 0 for 0x10.
3. DEPTH = 2, ready_in = 0; push 0x11 and 0x22 -> ready_out = 0 after 2 pushes; raise ready_in -> outputs 0x11 then 0x22 in order; ready_out returns 1 one cycle after the first pop.
4. FIFO at 1 entry, push and pop together for 10 cycles with incrementing data -> occupancy stays 1, in-order output, pkt_count = 10.
5. FIFO holding 2 entries; assert flush together with a valid matched push -> next cycle valid_out = 0 and ready_out = 1; pkt_count and id unchanged.
6. set_id with en_in = 0 -> match = 0 for all tags; buffered entries still drain to the PE; assert rst mid-drain -> valid_out = 0, id = 0, pkt_count = 0 the next cycle.
